// File: rtl/encoder.sv
// Registered Hamming(7,4) encoder with selectable even/odd parity sense.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high (clears b and out_valid)
//   select     parity sense: 0 = even, 1 = odd (parity bits inverted)
//   in_valid   qualifies a/select this cycle
//   a[3:0]     data nibble, a[0]=d1 .. a[3]=d4
//   b[6:0]     codeword, bit i = Hamming position i+1
//   out_valid  b holds a codeword captured from a valid input
//
// Optional build macro ENCODER_ERR_INJECT_EN adds:
//   inj_en     flip one codeword bit on a valid capture
//   inj_pos    1..7 selects b[0]..b[6]; 0 = no flip
module encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       select,
    input  logic       in_valid,
    input  logic [3:0] a,
`ifdef ENCODER_ERR_INJECT_EN
    input  logic       inj_en,
    input  logic [2:0] inj_pos,
`endif
    output logic [6:0] b,
    output logic       out_valid
);

    localparam int unsigned DATA_W = 4;
    localparam int unsigned CODE_W = 7;

    logic [DATA_W-1:0] d;
    logic              p1_c;
    logic              p2_c;
    logic              p4_c;
    logic [CODE_W-1:0] codeword_c;
    logic [CODE_W-1:0] flip_c;

    assign d = a;

    // Parity bits; odd sense simply inverts each check bit.
    always_comb begin
        p1_c = d[0] ^ d[1] ^ d[3] ^ select;
        p2_c = d[0] ^ d[2] ^ d[3] ^ select;
        p4_c = d[1] ^ d[2] ^ d[3] ^ select;
        codeword_c = {d[3], d[2], d[1], p4_c, d[0], p2_c, p1_c};
    end

    // Error-injection mask applied to the captured codeword.
`ifdef ENCODER_ERR_INJECT_EN
    always_comb begin
        flip_c = '0;
        if (inj_en && (inj_pos != 3'd0)) begin
            flip_c = CODE_W'(CODE_W'(1) << (inj_pos - 3'd1));
        end
    end
`else
    assign flip_c = '0;
`endif

    // Output register; reset overrides a concurrent valid input.
    always_ff @(posedge clk) begin
        if (rst) begin
            b         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                b <= codeword_c ^ flip_c;
            end
        end
    end

endmodule

// File: tb/tb_encoder.sv
// Self-checking bench for the Hamming(7,4) encoder: directed vector table,
// exhaustive (a, select) sweep against a generator-matrix model, and
// optional error-injection vectors when ENCODER_ERR_INJECT_EN is defined.
module tb_encoder;

    logic       clk;
    logic       rst;
    logic       select;
    logic       in_valid;
    logic [3:0] a;
    logic [6:0] b;
    logic       out_valid;
`ifdef ENCODER_ERR_INJECT_EN
    logic       inj_en;
    logic [2:0] inj_pos;
`endif

    int checks;
    int errors;

    encoder dut (
        .clk       (clk),
        .rst       (rst),
        .select    (select),
        .in_valid  (in_valid),
        .a         (a),
`ifdef ENCODER_ERR_INJECT_EN
        .inj_en    (inj_en),
        .inj_pos   (inj_pos),
`endif
        .b         (b),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       iv;
        logic       sel;
        logic [3:0] a;
        logic [6:0] exp_b;
        logic       exp_v;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic check_b(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: b got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: out_valid got %b expected %b", name, act, exp);
        end
    endtask

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    task automatic step(input logic r, input logic iv, input logic sel, input logic [3:0] data);
        @(negedge clk);
        rst      = r;
        in_valid = iv;
        select   = sel;
        a        = data;
        @(posedge clk);
        #1;
    endtask

    // Reference codeword from generator-matrix rows, independent of the parity equations.
    function automatic logic [6:0] model(input logic [3:0] data, input logic sel);
        logic [6:0] cw;
        cw = '0;
        if (data[0]) cw ^= 7'b0000111;
        if (data[1]) cw ^= 7'b0011001;
        if (data[2]) cw ^= 7'b0101010;
        if (data[3]) cw ^= 7'b1001011;
        if (sel)     cw ^= 7'b0001011;
        return cw;
    endfunction

    function automatic logic [2:0] syndrome(input logic [6:0] cw);
        logic [2:0] s;
        s[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        s[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        s[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        return s;
    endfunction

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        select   = 1'b0;
        a        = 4'h0;
`ifdef ENCODER_ERR_INJECT_EN
        inj_en   = 1'b0;
        inj_pos  = 3'd0;
`endif

        vecs[0]  = '{"reset_c1",      1'b1, 1'b0, 1'b0, 4'b0000, 7'h00, 1'b0};
        vecs[1]  = '{"reset_c2",      1'b1, 1'b0, 1'b0, 4'b0000, 7'h00, 1'b0};
        vecs[2]  = '{"d1011_even",    1'b0, 1'b1, 1'b0, 4'b1011, 7'h55, 1'b1};
        vecs[3]  = '{"d1011_odd",     1'b0, 1'b1, 1'b1, 4'b1011, 7'h5E, 1'b1};
        vecs[4]  = '{"d0000_even",    1'b0, 1'b1, 1'b0, 4'b0000, 7'h00, 1'b1};
        vecs[5]  = '{"d0000_odd",     1'b0, 1'b1, 1'b1, 4'b0000, 7'h0B, 1'b1};
        vecs[6]  = '{"d1111_even",    1'b0, 1'b1, 1'b0, 4'b1111, 7'h7F, 1'b1};
        vecs[7]  = '{"d1111_odd",     1'b0, 1'b1, 1'b1, 4'b1111, 7'h74, 1'b1};
        vecs[8]  = '{"recapture_55",  1'b0, 1'b1, 1'b0, 4'b1011, 7'h55, 1'b1};
        vecs[9]  = '{"hold_toggle1",  1'b0, 1'b0, 1'b1, 4'b0100, 7'h55, 1'b0};
        vecs[10] = '{"hold_toggle2",  1'b0, 1'b0, 1'b0, 4'b1111, 7'h55, 1'b0};
        vecs[11] = '{"rst_overrides", 1'b1, 1'b1, 1'b1, 4'b1111, 7'h00, 1'b0};
        vecs[12] = '{"after_reset",   1'b0, 1'b1, 1'b0, 4'b1011, 7'h55, 1'b1};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].iv, vecs[i].sel, vecs[i].a);
            check_b(vecs[i].name, b, vecs[i].exp_b);
            check_v(vecs[i].name, out_valid, vecs[i].exp_v);
        end

        // Back-to-back sweep of all 32 (a, select) combinations.
        for (int k = 0; k < 32; k++) begin
            logic [3:0] dv;
            logic       sv;
            logic [2:0] exp_s;
            dv = 4'(k);
            sv = 1'(k >> 4);
            step(1'b0, 1'b1, sv, dv);
            check_b($sformatf("sweep_a%0h_s%0d", dv, sv), b, model(dv, sv));
            exp_s = sv ? 3'b111 : 3'b000;
            checks++;
            if (syndrome(b) !== exp_s) begin
                errors++;
                $display("FAIL syndrome_a%0h_s%0d: got %b expected %b", dv, sv, syndrome(b), exp_s);
            end
        end
        check_v("sweep_valid", out_valid, 1'b1);

        // Mid-stream reset after a valid burst clears both outputs in one edge.
        step(1'b0, 1'b1, 1'b1, 4'b1111);
        check_b("pre_midrst", b, 7'h74);
        step(1'b1, 1'b0, 1'b0, 4'b0000);
        check_b("midrst", b, 7'h00);
        check_v("midrst", out_valid, 1'b0);

`ifdef ENCODER_ERR_INJECT_EN
        @(negedge clk);
        inj_en  = 1'b1;
        inj_pos = 3'd3;
        step(1'b0, 1'b1, 1'b0, 4'b1011);
        check_b("inj_pos3", b, 7'h51);
        @(negedge clk);
        inj_pos = 3'd0;
        step(1'b0, 1'b1, 1'b0, 4'b1011);
        check_b("inj_pos0", b, 7'h55);
        for (int p = 1; p <= 7; p++) begin
            logic [6:0] mask;
            mask = 7'b0000001 << (p - 1);
            @(negedge clk);
            inj_pos = 3'(p);
            step(1'b0, 1'b1, 1'b1, 4'b0110);
            check_b($sformatf("inj_sweep%0d", p), b, model(4'b0110, 1'b1) ^ mask);
        end
        @(negedge clk);
        inj_en  = 1'b0;
        inj_pos = 3'd5;
        step(1'b0, 1'b1, 1'b0, 4'b1011);
        check_b("inj_disabled", b, 7'h55);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
